// File: rtl/cordic_pkg.sv
// Shared CORDIC constants: angle format, arctangent table, gain
// inverse and FSM states for the rotation and vectoring engines.
package cordic_pkg;

    localparam int ANGLE_W = 32;
    localparam logic [ANGLE_W-1:0] ANGLE_180 = 32'h8000_0000;
    localparam logic [15:0] INV_GAIN = 16'h9B75;

    // round(atan(2^-i) / 2pi * 2^32)
    localparam logic [ANGLE_W-1:0] ATAN [32] = '{
        32'h2000_0000, 32'h12E4_051E, 32'h09FB_385B, 32'h0511_11D4,
        32'h028B_0D43, 32'h0145_D7E1, 32'h00A2_F61E, 32'h0051_7C55,
        32'h0028_BE53, 32'h0014_5F2F, 32'h000A_2F98, 32'h0005_17CC,
        32'h0002_8BE6, 32'h0001_45F3, 32'h0000_A2FA, 32'h0000_517D,
        32'h0000_28BE, 32'h0000_145F, 32'h0000_0A30, 32'h0000_0518,
        32'h0000_028C, 32'h0000_0146, 32'h0000_00A3, 32'h0000_0051,
        32'h0000_0029, 32'h0000_0014, 32'h0000_000A, 32'h0000_0005,
        32'h0000_0003, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000
    };

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROTATE = 2'd1,
        COMP   = 2'd2,
        DONE   = 2'd3
    } cordic_state_e;

endpackage

// File: rtl/cordic_vectoring_if.sv
// Operand/result handshake bundle for the vectoring CORDIC.
// The master side is the upstream producer / downstream consumer.
interface cordic_vectoring_if #(
    parameter int XY_SIZE = 16
);
    import cordic_pkg::*;

    logic                      in_valid;
    logic                      in_ready;
    logic signed [XY_SIZE-1:0] xin;
    logic signed [XY_SIZE-1:0] yin;
    logic                      out_valid;
    logic                      out_ready;
    logic [XY_SIZE+1:0]        mag;
    logic [ANGLE_W-1:0]        angle;

    modport master (
        output in_valid, xin, yin, out_ready,
        input  in_ready, out_valid, mag, angle
    );

    modport slave (
        input  in_valid, xin, yin, out_ready,
        output in_ready, out_valid, mag, angle
    );

endinterface

// File: rtl/cordic_vec_microrot.sv
// One vectoring micro-rotation: steers y toward zero by +/-atan(2^-i)
// and accumulates the applied angle in z.
module cordic_vec_microrot
    import cordic_pkg::*;
#(
    parameter int W  = 18,
    parameter int IW = 4
) (
    input  logic signed [W-1:0]       x_i,
    input  logic signed [W-1:0]       y_i,
    input  logic        [ANGLE_W-1:0] z_i,
    input  logic        [IW-1:0]      i_i,
    output logic signed [W-1:0]       x_o,
    output logic signed [W-1:0]       y_o,
    output logic        [ANGLE_W-1:0] z_o
);

    logic signed [W-1:0]  xs;
    logic signed [W-1:0]  ys;
    logic [4:0]           idx;
    logic [ANGLE_W-1:0]   at;
    logic                 y_pos;

    assign xs    = x_i >>> i_i;
    assign ys    = y_i >>> i_i;
    assign idx   = 5'(i_i);
    assign at    = ATAN[idx];
    assign y_pos = ~y_i[W-1];

    always_comb begin
        x_o = y_pos ? (x_i + ys) : (x_i - ys);
        y_o = y_pos ? (y_i - xs) : (y_i + xs);
        z_o = y_pos ? (z_i + at) : (z_i - at);
    end

endmodule

// File: rtl/cordic_vectoring.sv
// Iterative vectoring-mode CORDIC: magnitude and atan2 angle.
// Define CORDIC_VEC_GAIN_COMP_EN to add the gain-compensation state.
module cordic_vectoring
    import cordic_pkg::*;
#(
    parameter int XY_SIZE = 16
) (
    input  logic               clock,
    input  logic               reset,
    cordic_vectoring_if.slave  bus
);

    localparam int W   = XY_SIZE + 2;
    localparam int IW  = $clog2(XY_SIZE);
    localparam int STG = XY_SIZE;

    cordic_state_e state_q, state_d;

    logic signed [W-1:0]  x_q, x_d;
    logic signed [W-1:0]  y_q, y_d;
    logic [ANGLE_W-1:0]   z_q, z_d;
    logic [IW-1:0]        iter_q, iter_d;
    logic                 zero_q, zero_d;
    logic [W-1:0]         mag_q, mag_d;
    logic [ANGLE_W-1:0]   angle_q, angle_d;

    logic signed [W-1:0]  xe, ye;
    logic signed [W-1:0]  xr, yr;
    logic [ANGLE_W-1:0]   zr;
    logic                 last;

    assign xe   = {{(W-XY_SIZE){bus.xin[XY_SIZE-1]}}, bus.xin};
    assign ye   = {{(W-XY_SIZE){bus.yin[XY_SIZE-1]}}, bus.yin};
    assign last = (iter_q == IW'(STG - 1));

    cordic_vec_microrot #(
        .W  (W),
        .IW (IW)
    ) u_rot (
        .x_i (x_q),
        .y_i (y_q),
        .z_i (z_q),
        .i_i (iter_q),
        .x_o (xr),
        .y_o (yr),
        .z_o (zr)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            iter_q  <= '0;
            zero_q  <= 1'b0;
            mag_q   <= '0;
            angle_q <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            iter_q  <= iter_d;
            zero_q  <= zero_d;
            mag_q   <= mag_d;
            angle_q <= angle_d;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        iter_d  = iter_q;
        zero_d  = zero_q;
        mag_d   = mag_q;
        angle_d = angle_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    // fold the left half-plane onto the right
                    if (xe[W-1]) begin
                        x_d = -xe;
                        y_d = -ye;
                        z_d = ANGLE_180;
                    end else begin
                        x_d = xe;
                        y_d = ye;
                        z_d = '0;
                    end
                    zero_d  = (bus.xin == '0) && (bus.yin == '0);
                    iter_d  = '0;
                    state_d = ROTATE;
                end
            end
            ROTATE: begin
                x_d    = xr;
                y_d    = yr;
                z_d    = zr;
                iter_d = iter_q + IW'(1);
                if (last) begin
`ifdef CORDIC_VEC_GAIN_COMP_EN
                    state_d = COMP;
`else
                    state_d = DONE;
                    mag_d   = zero_q ? '0 : W'($unsigned(xr));
                    angle_d = zero_q ? '0 : zr;
`endif
                end
            end
`ifdef CORDIC_VEC_GAIN_COMP_EN
            COMP: begin
                state_d = DONE;
                mag_d   = zero_q ? '0 : W'(((W+16)'($unsigned(x_q))
                          * (W+16)'(INV_GAIN)) >> 16);
                angle_d = zero_q ? '0 : z_q;
            end
`endif
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.mag       = mag_q;
    assign bus.angle     = angle_q;

endmodule

// File: tb/tb_cordic_vectoring.sv
// Directed and random checks of cordic_vectoring against an
// atan2/sqrt reference model.
module tb_cordic_vectoring;
    import cordic_pkg::*;

    localparam int  XY  = 16;
    localparam real PI  = 3.14159265358979;
    localparam real TURN = 4294967296.0;
    localparam real LPR = TURN / (2.0 * PI);
`ifdef CORDIC_VEC_GAIN_COMP_EN
    localparam int  LAT = XY + 1;
    localparam real KG  = 1.0;
`else
    localparam int  LAT = XY;
    localparam real KG  = 1.6467602581;
`endif
    localparam longint MAG_TOL = 16;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;

    cordic_vectoring_if #(.XY_SIZE(XY)) bus ();

    cordic_vectoring #(.XY_SIZE(XY)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [31:0] ref_angle(int x, int y);
        real a;
        a = $atan2(real'(y), real'(x)) * LPR;
        if (a < 0.0) a = a + TURN;
        return 32'(longint'(a));
    endfunction

    function automatic real radius(int x, int y);
        return $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
    endfunction

    function automatic longint ref_mag(int x, int y);
        return longint'(KG * radius(x, y));
    endfunction

    // residual rotation plus truncation noise over the vector length
    function automatic longint ang_tol(int x, int y);
        return longint'(20861.0 + 16.0 * LPR / radius(x, y));
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_mag(input string tag, input logic [17:0] obs,
                           input longint exp);
        longint d;
        d = longint'(obs) - exp;
        if (d < 0) d = -d;
        n_vec++;
        assert (!$isunknown(obs) && d <= MAG_TOL) else begin
            n_bad++;
            $error("FAIL %s mag: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_ang(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp, input longint tol);
        logic [31:0] d;
        longint      sd;
        d  = obs - exp;
        sd = longint'($signed(d));
        if (sd < 0) sd = -sd;
        n_vec++;
        assert (!$isunknown(obs) && sd <= tol) else begin
            n_bad++;
            $error("FAIL %s angle: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic accept(input int x, input int y);
        int g;
        g = 0;
        @(negedge clock);
        while (bus.in_ready !== 1'b1 && g < 100) begin
            @(negedge clock);
            g++;
        end
        chk("accept_ready", 64'(bus.in_ready), 64'd1);
        bus.xin      = 16'(x);
        bus.yin      = 16'(y);
        bus.in_valid = 1'b1;
        @(posedge clock);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int cyc;
        cyc = 0;
        while (bus.out_valid !== 1'b1 && cyc < 200) begin
            @(posedge clock);
            #1 cyc++;
        end
        chk({tag, " latency"}, 64'(cyc), 64'(LAT));
    endtask

    task automatic check_result(input string tag, input int x, input int y);
        if (x == 0 && y == 0) begin
            chk({tag, " mag"}, 64'(bus.mag), 64'd0);
            chk({tag, " angle"}, 64'(bus.angle), 64'd0);
        end else begin
            chk_mag(tag, bus.mag, ref_mag(x, y));
            chk_ang(tag, bus.angle, ref_angle(x, y), ang_tol(x, y));
        end
    endtask

    task automatic consume(input string tag);
        @(negedge clock);
        bus.out_ready = 1'b1;
        @(posedge clock);
        #1 bus.out_ready = 1'b0;
        chk({tag, " out_valid_clr"}, 64'(bus.out_valid), 64'd0);
        chk({tag, " in_ready_back"}, 64'(bus.in_ready), 64'd1);
    endtask

    task automatic vec(input string tag, input int x, input int y);
        accept(x, y);
        wait_done(tag);
        check_result(tag, x, y);
        consume(tag);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.xin       = '0;
        bus.yin       = '0;

        #12;
        chk("rst in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst mag", 64'(bus.mag), 64'd0);
        chk("rst angle", 64'(bus.angle), 64'd0);
        @(negedge clock);
        reset = 1'b0;

        vec("x_axis", 16000, 0);
        vec("neg_x", -10000, 0);
        vec("min_x", -32768, 0);
        vec("neg_y", 0, -12000);
        vec("zero", 0, 0);
        vec("corner", -32768, -32768);

        // 45 deg with in_valid held high while busy
        accept(10000, 10000);
        @(negedge clock);
        bus.xin      = 16'(-5);
        bus.yin      = 16'(7);
        bus.in_valid = 1'b1;
        wait_done("diag");
        bus.in_valid = 1'b0;
        check_result("diag", 10000, 10000);
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            chk("hold out_valid", 64'(bus.out_valid), 64'd1);
            chk("hold in_ready", 64'(bus.in_ready), 64'd0);
            check_result("hold", 10000, 10000);
        end
        consume("diag");

        // reset in the middle of iteration 7
        accept(-20000, 15000);
        repeat (7) @(posedge clock);
        #2 reset = 1'b1;
        #1;
        chk("midrst out_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst mag", 64'(bus.mag), 64'd0);
        chk("midrst angle", 64'(bus.angle), 64'd0);
        chk("midrst in_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clock);
        reset = 1'b0;
        vec("pyth", 3000, 4000);

        for (int n = 0; n < 12; n++) begin
            int     x, y;
            longint r2;
            do begin
                x  = int'($urandom_range(65535)) - 32768;
                y  = int'($urandom_range(65535)) - 32768;
                r2 = longint'(x) * x + longint'(y) * y;
            end while (r2 < 64'd268435456);
            vec($sformatf("rnd%0d", n), x, y);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
